// File: rtl/gray_step_rx.sv
// Gray-code step receiver: synchronises a 3-bit Gray input, decodes it, and counts single-step advances.
// Define GRAY_STEP_ERR_CHECK_EN to flag multi-step jumps instead of counting them.
module gray_step_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [2:0]       grayIn,
    input  logic             clr,
    output logic [2:0]       binOut,
    output logic             stepPulse,
    output logic [CNT_W-1:0] stepCount,
    output logic             errFlag
);

    localparam logic [CNT_W+3:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        gray2bin = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    logic [2:0]       sync_r [SYNC_STAGES];
    logic [2:0]       gray_s;
    logic [2:0]       cur_bin_s;
    logic [2:0]       delta_s;
    logic [2:0]       add_s;
    logic             step_s;
    logic [CNT_W+3:0] sum_s;
    logic [CNT_W-1:0] next_cnt_s;
    // bin_r doubles as the previous-cycle decode used for the delta
    logic [2:0]       bin_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;

    assign gray_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous Gray input
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 3'b000;
            end
        end else begin
            sync_r[0] <= grayIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

`ifdef GRAY_STEP_ERR_CHECK_EN
    logic err_s;
    logic err_r;
`endif

    // Step classification and saturating count update
    always_comb begin
        cur_bin_s = gray2bin(gray_s);
        delta_s   = cur_bin_s - bin_r;
        step_s    = 1'b0;
        add_s     = 3'd0;
`ifdef GRAY_STEP_ERR_CHECK_EN
        err_s     = 1'b0;
`endif
        case (delta_s)
            3'd0: begin
                step_s = 1'b0;
            end
            3'd1: begin
                step_s = 1'b1;
                add_s  = 3'd1;
            end
            default: begin
`ifdef GRAY_STEP_ERR_CHECK_EN
                err_s  = 1'b1;
`else
                step_s = 1'b1;
                add_s  = delta_s;
`endif
            end
        endcase
        sum_s = {4'b0000, cnt_r} + {{(CNT_W+1){1'b0}}, add_s};
        if (sum_s > CNT_MAX) begin
            next_cnt_s = {CNT_W{1'b1}};
        end else begin
            next_cnt_s = sum_s[CNT_W-1:0];
        end
    end

    // Decode, pulse and counter registers; clr wins over a same-cycle step
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bin_r   <= 3'b000;
            pulse_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            bin_r   <= cur_bin_s;
            pulse_r <= step_s;
            if (clr) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (step_s) begin
                cnt_r <= next_cnt_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

`ifdef GRAY_STEP_ERR_CHECK_EN
    // Sticky illegal-jump flag
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            err_r <= 1'b0;
        end else if (clr) begin
            err_r <= 1'b0;
        end else if (err_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
    assign errFlag = err_r;
`else
    assign errFlag = 1'b0;
`endif

    assign binOut    = bin_r;
    assign stepPulse = pulse_r;
    assign stepCount = cnt_r;

endmodule

// File: tb/tb_gray_step_rx.sv
// Self-checking bench for gray_step_rx: two instances (8-bit/2-stage and 4-bit/3-stage) share stimulus.
module tb_gray_step_rx;

    logic       clk = 1'b0;
    logic       rstN;
    logic       clr;
    logic [2:0] gray_in;
    logic [2:0] bin8, bin4;
    logic       p8s, p4s;
    logic [7:0] c8;
    logic [3:0] c4;
    logic       e8, e4;

    gray_step_rx #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk(clk), .rstN(rstN), .grayIn(gray_in), .clr(clr),
        .binOut(bin8), .stepPulse(p8s), .stepCount(c8), .errFlag(e8));

    gray_step_rx #(.SYNC_STAGES(3), .CNT_W(4)) dut4 (
        .clk(clk), .rstN(rstN), .grayIn(gray_in), .clr(clr),
        .binOut(bin4), .stepPulse(p4s), .stepCount(c4), .errFlag(e4));

    always #5 clk = ~clk;

`ifdef GRAY_STEP_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    int errors = 0;
    int checks = 0;
    int p8_cnt = 0;
    int p4_cnt = 0;
    int e_bin = 0, e_c8 = 0, e_c4 = 0, e_p = 0;
    bit e_err = 1'b0;

    // pulse-cycle monitor: a pulse wider than one cycle inflates the count
    always @(negedge clk) begin
        if (p8s === 1'b1) p8_cnt++;
        if (p4s === 1'b1) p4_cnt++;
    end

    function automatic int g2b_ref(input logic [2:0] g);
        for (int i = 0; i < 8; i++) if (seq[i] == g) return i;
        return 0;
    endfunction

    task automatic model_apply(input logic [2:0] g, input bit clr_on);
        int nb;
        int d;
        nb = g2b_ref(g);
        d = (nb - e_bin + 8) % 8;
        e_bin = nb;
        if (d == 1 || (d >= 2 && !ERR_EN)) begin
            e_p++;
            e_c8 = (e_c8 + d > 255) ? 255 : e_c8 + d;
            e_c4 = (e_c4 + d > 15) ? 15 : e_c4 + d;
        end else if (d >= 2) begin
            e_err = 1'b1;
        end
        if (clr_on) begin
            e_c8 = 0;
            e_c4 = 0;
            e_err = 1'b0;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc(3);
        checks++; if ({bin8, p8s, c8, e8} !== 13'd0) begin errors++; $display("FAIL reset_dut8 got %h exp 0", {bin8, p8s, c8, e8}); end
        checks++; if ({bin4, p4s, c4, e4} !== 9'd0) begin errors++; $display("FAIL reset_dut4 got %h exp 0", {bin4, p4s, c4, e4}); end
        rstN = 1'b1;
        cyc(4);
        checks++; if (p8_cnt != 0 || c8 !== 8'd0) begin errors++; $display("FAIL reset_release got pulses=%0d cnt=%0d exp 0/0", p8_cnt, c8); end
    endtask

    task automatic test_sequence;
        for (int i = 1; i < 8; i++) begin
            gray_in = seq[i];
            model_apply(seq[i], 1'b0);
            cyc(2);
            checks++; if (bin8 !== 3'(i - 1) || p8s !== 1'b0) begin errors++; $display("FAIL seq_early%0d got bin=%0d pulse=%b exp bin=%0d pulse=0", i, bin8, p8s, i - 1); end
            cyc(1);
            checks++; if (bin8 !== 3'(i) || p8s !== 1'b1) begin errors++; $display("FAIL seq_lat%0d got bin=%0d pulse=%b exp bin=%0d pulse=1", i, bin8, p8s, i); end
            cyc(1);
            checks++; if (p8s !== 1'b0) begin errors++; $display("FAIL seq_pw%0d got pulse=%b exp 0", i, p8s); end
        end
        cyc(3);
        checks++; if (c8 !== 8'd7 || p8_cnt != 7) begin errors++; $display("FAIL seq_cnt8 got cnt=%0d pulses=%0d exp 7/7", c8, p8_cnt); end
        checks++; if (c4 !== 4'd7 || p4_cnt != 7 || bin4 !== 3'd7) begin errors++; $display("FAIL seq_dut4 got cnt=%0d pulses=%0d bin=%0d exp 7/7/7", c4, p4_cnt, bin4); end
    endtask

    task automatic test_wrap;
        gray_in = 3'b000;
        model_apply(3'b000, 1'b0);
        cyc(6);
        checks++; if (bin8 !== 3'd0 || c8 !== 8'(e_c8) || e8 !== e_err) begin errors++; $display("FAIL wrap_dut8 got bin=%0d cnt=%0d err=%b exp 0/%0d/%b", bin8, c8, e8, e_c8, e_err); end
        checks++; if (p8_cnt != e_p || c4 !== 4'(e_c4)) begin errors++; $display("FAIL wrap_pulse got pulses=%0d cnt4=%0d exp %0d/%0d", p8_cnt, c4, e_p, e_c4); end
    endtask

    task automatic test_jump;
        gray_in = 3'b011;
        model_apply(3'b011, 1'b0);
        cyc(6);
        checks++; if (bin8 !== 3'd2 || c8 !== 8'(e_c8) || e8 !== e_err) begin errors++; $display("FAIL jump_dut8 got bin=%0d cnt=%0d err=%b exp 2/%0d/%b", bin8, c8, e8, e_c8, e_err); end
        checks++; if (p8_cnt != e_p || p4_cnt != e_p || e4 !== e_err) begin errors++; $display("FAIL jump_pulse got p8=%0d p4=%0d err4=%b exp %0d/%b", p8_cnt, p4_cnt, e4, e_p, e_err); end
    endtask

    task automatic test_clr;
        logic [2:0] g;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        model_apply(seq[e_bin], 1'b1);
        for (int i = 0; i < 3; i++) begin
            g = seq[(e_bin + 1) % 8];
            gray_in = g;
            model_apply(g, 1'b0);
            cyc(5);
        end
        checks++; if (c8 !== 8'd3 || c4 !== 4'd3 || e8 !== 1'b0) begin errors++; $display("FAIL clr_pre got cnt8=%0d cnt4=%0d err=%b exp 3/3/0", c8, c4, e8); end
        g = seq[(e_bin + 1) % 8];
        gray_in = g;
        clr = 1'b1;
        model_apply(g, 1'b1);
        cyc(5);
        clr = 1'b0;
        cyc(3);
        checks++; if (c8 !== 8'd0 || c4 !== 4'd0 || e8 !== 1'b0 || e4 !== 1'b0) begin errors++; $display("FAIL clr_step got cnt8=%0d cnt4=%0d err=%b%b exp 0/0/00", c8, c4, e8, e4); end
        checks++; if (p8_cnt != e_p || p4_cnt != e_p || bin8 !== 3'(e_bin)) begin errors++; $display("FAIL clr_pulse got p8=%0d p4=%0d bin=%0d exp %0d/%0d", p8_cnt, p4_cnt, bin8, e_p, e_bin); end
    endtask

    task automatic test_saturation;
        logic [2:0] g;
        int p_start;
        p_start = p4_cnt;
        for (int i = 0; i < 20; i++) begin
            g = seq[(e_bin + 1) % 8];
            gray_in = g;
            model_apply(g, 1'b0);
            cyc(5);
        end
        cyc(3);
        checks++; if (c4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got %0d exp 15", c4); end
        checks++; if (p4_cnt - p_start != 20) begin errors++; $display("FAIL sat_pulses got %0d exp 20", p4_cnt - p_start); end
        checks++; if (c8 !== 8'(e_c8)) begin errors++; $display("FAIL sat_cnt8 got %0d exp %0d", c8, e_c8); end
    endtask

    task automatic test_random;
        logic [2:0] g;
        int r;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) g = seq[(e_bin + 1) % 8];
            else if (r == 6) g = seq[e_bin];
            else g = 3'($urandom_range(0, 7));
            gray_in = g;
            model_apply(g, 1'b0);
            cyc(6);
            checks++; if (bin8 !== 3'(e_bin) || bin4 !== 3'(e_bin)) begin errors++; $display("FAIL rnd_bin%0d got %0d/%0d exp %0d", i, bin8, bin4, e_bin); end
            checks++; if (c8 !== 8'(e_c8) || c4 !== 4'(e_c4)) begin errors++; $display("FAIL rnd_cnt%0d got %0d/%0d exp %0d/%0d", i, c8, c4, e_c8, e_c4); end
            checks++; if (e8 !== e_err || e4 !== e_err) begin errors++; $display("FAIL rnd_err%0d got %b/%b exp %b", i, e8, e4, e_err); end
            checks++; if (p8_cnt != e_p || p4_cnt != e_p) begin errors++; $display("FAIL rnd_pulse%0d got %0d/%0d exp %0d", i, p8_cnt, p4_cnt, e_p); end
        end
    endtask

    task automatic test_reset_midcount;
        logic [2:0] g;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        model_apply(seq[e_bin], 1'b1);
        for (int i = 0; i < 5; i++) begin
            g = seq[(e_bin + 1) % 8];
            gray_in = g;
            model_apply(g, 1'b0);
            cyc(5);
        end
        checks++; if (c8 !== 8'd5 || c4 !== 4'd5) begin errors++; $display("FAIL mid_pre got %0d/%0d exp 5/5", c8, c4); end
        gray_in = seq[(e_bin + 1) % 8];
        @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checks++; if ({bin8, p8s, c8, e8} !== 13'd0 || {bin4, p4s, c4, e4} !== 9'd0) begin errors++; $display("FAIL mid_async got %h/%h exp 0/0", {bin8, p8s, c8, e8}, {bin4, p4s, c4, e4}); end
        gray_in = 3'b000;
        cyc(2);
        checks++; if ({bin8, p8s, c8, e8} !== 13'd0 || {bin4, p4s, c4, e4} !== 9'd0) begin errors++; $display("FAIL mid_hold got %h/%h exp 0/0", {bin8, p8s, c8, e8}, {bin4, p4s, c4, e4}); end
        rstN = 1'b1;
        e_bin = 0; e_c8 = 0; e_c4 = 0; e_err = 1'b0;
        cyc(6);
        checks++; if (p8_cnt != e_p || p4_cnt != e_p) begin errors++; $display("FAIL mid_nopulse got %0d/%0d exp %0d", p8_cnt, p4_cnt, e_p); end
        checks++; if (bin8 !== 3'd0 || c8 !== 8'd0 || bin4 !== 3'd0 || c4 !== 4'd0) begin errors++; $display("FAIL mid_after got bin=%0d/%0d cnt=%0d/%0d exp 0", bin8, bin4, c8, c4); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rstN = 1'b0;
        clr = 1'b0;
        gray_in = 3'b000;
        test_reset();
        test_sequence();
        test_wrap();
        test_jump();
        test_clr();
        test_saturation();
        test_random();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_step_rx.md
GRAY_STEP_RX -- requirements
Module: gray_step_rx

Purpose: downstream consumer of the 3-bit Gray-coded fifo output (dataOut). Synchronises it, decodes it to binary, detects single-step advances, and counts them.

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of synchroniser flops on grayIn (legal range 2..4).
REQ-002 Parameter: CNT_W, 8, width of stepCount (legal range 2..16).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rstN  input  1  reset; asynchronous, active-low.
REQ-005 Port: grayIn  input  3  Gray-coded value, driven from the fifo dataOut; may be asynchronous to clk.
REQ-006 Port: clr  input  1  synchronous clear of stepCount and errFlag.
REQ-007 Port: binOut  output  3  registered binary decode of the synchronised grayIn.
REQ-008 Port: stepPulse  output  1  one-cycle pulse per accepted advance.
REQ-009 Port: stepCount  output  CNT_W  saturating count of accepted steps.
REQ-010 Port: errFlag  output  1  sticky illegal-transition flag.

Function
REQ-011 Gray sequence SHALL be 000,001,011,010,110,111,101,100, decoding to binary 0..7.
REQ-012 grayIn SHALL pass through SYNC_STAGES flops; the last stage is grayS.
REQ-013 Register prevBin SHALL hold the decode of grayS from the previous cycle.
REQ-014 delta SHALL be (gray2bin(grayS) - prevBin) mod 8, computed in 3 bits.
REQ-015 binOut SHALL update one cycle after grayS changes, giving a total latency of SYNC_STAGES+1 cycles from a grayIn change.
REQ-016 delta==0: no stepPulse and no count change.
REQ-017 delta==1: stepPulse=1 for exactly one cycle, registered with binOut, and stepCount increments by 1.
REQ-018 Wrap-around from 100 to 000 (bin 7 to 0) SHALL give delta==1 and SHALL be treated as a legal step.
REQ-019 delta>=2 SHALL be handled as defined under Configuration.
REQ-020 stepCount SHALL saturate at 2^CNT_W-1; further steps still pulse stepPulse but do not change the count.
REQ-021 When clr=1, stepCount and errFlag SHALL be 0 on the next edge; clr has priority over any step or error in the same cycle, and that step is not counted (stepPulse still fires).
REQ-022 binOut and prevBin SHALL be unaffected by clr.

Reset
REQ-023 rstN=0 SHALL immediately clear all synchroniser flops, prevBin, binOut, stepPulse, stepCount and errFlag to 0, without waiting for a clk edge.
REQ-024 Reset asserted mid-operation SHALL discard any in-flight synchroniser contents.
REQ-025 After rstN deassertion, the first non-zero grayS SHALL be evaluated against prevBin=0.
REQ-026 rstN deassertion SHALL take effect on the first clk edge after release, with no extra cycles.

Configuration
REQ-027 Macro GRAY_STEP_ERR_CHECK_EN SHALL control illegal-transition handling.
REQ-028 With GRAY_STEP_ERR_CHECK_EN defined, delta>=2 SHALL:
  - set errFlag (sticky until clr or reset);
  - leave stepCount unchanged;
  - assert no stepPulse;
  - still update binOut and prevBin.
REQ-029 Without GRAY_STEP_ERR_CHECK_EN, errFlag SHALL be tied to 0 and delta>=2 SHALL:
  - add delta to stepCount, with saturation;
  - assert stepPulse for one cycle.

Verification
REQ-030 Reset: rstN=0 for 2 cycles in mid-count (stepCount=5) -> all outputs 0 during reset; after release, grayIn=000 produces no pulse.
REQ-031 Sequence: grayIn walks 000..100, one code every 4 cycles, SYNC_STAGES=2 ->
  - binOut reads 1..7, each 3 cycles after its grayIn change;
  - 7 stepPulses;
  - stepCount=7.
REQ-032 Wrap: from 100, drive grayIn=000 -> binOut=0, one stepPulse, stepCount=8, errFlag=0.
REQ-033 Jump: from 000, drive grayIn=011 (bin 2) ->
  - macro defined: errFlag=1, stepCount unchanged, no pulse;
  - macro undefined: stepCount+2, one pulse.
REQ-034 clr coincident with a legal step, stepCount=3 -> stepCount=0, errFlag=0, stepPulse=1.
REQ-035 Saturation: CNT_W=4, 20 legal steps -> stepCount holds 15, and 20 stepPulses are observed.
